// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage in front of the IF/ID register.
//
// Owns the program counter, fetches over a req/ack instruction bus and hands
// the fetched pc/instruction pair to IF/ID. Raises a stall request while no
// instruction is available. Branch redirects (from ID) and flush redirects
// (from the control unit) are applied here.
//
// Optional feature macro: IF_IBUS_TIMEOUT_EN
//   defined   : 8-bit wait counter; after TIMEOUT_CYCLES consecutive un-acked
//               request cycles, ibus_err_o pulses, the FSM drops back to
//               S_RESET for one cycle and the same pc is requested again.
//   undefined : no counter, the stage waits forever, ibus_err_o tied low.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   stall[5:0]          pipeline stall vector, bit 1 stops IF
//   branch_flag_i/_target_i  taken branch from ID and its target
//   flush_i, new_pc_i   flush redirect (highest priority)
//   ibus_req_o/addr_o   fetch request and address (= pc)
//   ibus_ack_i/data_i   fetch acknowledge and instruction
//   ibus_err_o          one-cycle bus timeout pulse
//   if_pc, if_inst      pc/instruction presented to IF/ID
//   stallreq_o          IF stall request to the stall controller
//   dbg_state_o         current FSM state (S_RESET=0, S_REQ=1, S_HOLD=2)
//
// Bus handshake: ibus_req_o is the "valid" of a fetch. Once raised it stays
// high with ibus_addr_o stable until the cycle in which ibus_ack_i is seen
// high; that cycle completes the transfer and ibus_data_i is consumed in it.
// ibus_ack_i is ignored whenever ibus_req_o is low. Only flush, reset and
// timeout may withdraw a pending request.
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_data_i,
  output logic        ibus_err_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_inst;
  logic        r_hold_valid;
  logic        r_br_pending;
  logic [31:0] r_br_target;

  logic        w_stop;
  logic        w_advance;
  logic        w_capture;
  logic        w_timeout;
  logic [31:0] w_pc_nxt;
  logic        w_req;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_inst;
  logic        w_stallreq;

  assign w_stop = stall[1];

  // A branch seen this cycle beats an older latched one; otherwise fall
  // through sequentially (32-bit add wraps naturally).
  assign w_pc_nxt = branch_flag_i ? branch_target_i :
                    r_br_pending  ? r_br_target     :
                                    r_pc + 32'd4;

  // ---------------------------------------------------------------------
  // Next-state and combinational outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_capture   = 1'b0;
    w_req       = 1'b0;
    w_if_pc     = 32'd0;
    w_if_inst   = 32'd0;
    w_stallreq  = 1'b0;

    case (r_state)
      S_RESET: begin
        w_state_nxt = S_REQ;
      end

      S_REQ: begin
        w_req = 1'b1;
        // During a flush the IF/ID pair is a bubble and any ack is dropped.
        if (!flush_i) begin
          if (ibus_ack_i) begin
            w_if_pc   = r_pc;
            w_if_inst = ibus_data_i;
            if (w_stop) begin
              w_capture   = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_advance = 1'b1;
            end
          end else begin
            w_stallreq = 1'b1;
            if (w_timeout) begin
              w_state_nxt = S_RESET;
            end
          end
        end
      end

      S_HOLD: begin
        if (!flush_i) begin
          if (r_hold_valid) begin
            w_if_pc   = r_hold_pc;
            w_if_inst = r_hold_inst;
          end
          if (!w_stop) begin
            w_advance   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end

      default: begin
        w_state_nxt = S_RESET;
      end
    endcase

    if (flush_i) begin
      w_state_nxt = S_REQ;
    end
  end

  assign ibus_req_o  = w_req;
  assign ibus_addr_o = r_pc;
  assign if_pc       = w_if_pc;
  assign if_inst     = w_if_inst;
  assign stallreq_o  = w_stallreq;
  assign dbg_state_o = r_state;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (flush_i) begin
      r_pc <= new_pc_i;
    end else if (w_advance) begin
      r_pc <= w_pc_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Pending branch: a branch that arrives while pc cannot move is kept
  // until the next advance. A newer branch replaces the latched target.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_pending <= 1'b0;
      r_br_target  <= 32'd0;
    end else if (flush_i) begin
      r_br_pending <= 1'b0;
    end else if (w_advance) begin
      r_br_pending <= 1'b0;
    end else if (branch_flag_i) begin
      r_br_pending <= 1'b1;
      r_br_target  <= branch_target_i;
    end
  end

  // ---------------------------------------------------------------------
  // Hold buffer: keeps an acked instruction while IF is stopped.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_valid <= 1'b0;
      r_hold_pc    <= 32'd0;
      r_hold_inst  <= 32'd0;
    end else if (flush_i) begin
      r_hold_valid <= 1'b0;
    end else if (w_capture) begin
      r_hold_valid <= 1'b1;
      r_hold_pc    <= r_pc;
      r_hold_inst  <= ibus_data_i;
    end else if (w_advance && (r_state == S_HOLD)) begin
      r_hold_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Bus timeout
  // ---------------------------------------------------------------------
`ifdef IF_IBUS_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_err;
  logic       w_wait_cycle;

  // A cycle that counts toward the timeout: request out, no ack, no flush.
  assign w_wait_cycle = (r_state == S_REQ) && !ibus_ack_i && !flush_i;
  assign w_timeout    = (r_to_cnt == (TIMEOUT_CYCLES - 8'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_wait_cycle && w_timeout;
      if (!w_wait_cycle || w_timeout) begin
        r_to_cnt <= 8'd0;
      end else begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
    end
  end

  assign ibus_err_o = r_err;

  logic w_unused;
  assign w_unused = ^{stall[5:2], stall[0]};
`else
  assign w_timeout  = 1'b0;
  assign ibus_err_o = 1'b0;

  logic w_unused;
  assign w_unused = ^{stall[5:2], stall[0], TIMEOUT_CYCLES};
`endif

endmodule
